mic1_mem_arbiter: RTL and testbench
===================================

# mic1_mem_arbiter

Shares the single external memory port of the MIC-1 between the word path (MAR/MDR read and write) and the byte path (PC/MBR instruction fetch). It accepts the `rd`/`wr`/`fetch` bits of the current microinstruction, serialises the resulting accesses over a req/ack memory handshake, and loads MDR and MBR. While an access is outstanding it holds the control path through `stall`, so MPC and the datapath registers freeze.

## Interface
- `ADDR_W`, default 32: memory byte-address width.
- `DATA_W`, default 32: memory word width; fixed at 32 for MIC-1.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd` in 1: MIR word-read request.
- `wr` in 1: MIR word-write request.
- `fetch` in 1: MIR byte-fetch request.
- `MAR` in ADDR_W: word address.
- `MDR_q` in DATA_W: current MDR contents, used as write data.
- `PC` in ADDR_W: byte address for fetch.
- `mem_req` out 1: memory request; held until acknowledged.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W: word-aligned byte address.
- `mem_wdata` out DATA_W: write data.
- `mem_ack` in 1: memory completes the access in this cycle.
- `mem_rdata` in DATA_W: read data, valid when `mem_ack` = 1.
- `mdr_d` out DATA_W: value to load into MDR.
- `mdr_load` out 1: one-cycle MDR load strobe.
- `mbr_d` out 8: byte to load into MBR.
- `mbr_load` out 1: one-cycle MBR load strobe.
- `stall` out 1: hold MPC and the datapath.
- `err` out 1: one-cycle pulse when `rd` and `wr` are asserted together.
- `stall_cnt` out CNT_W: saturating count of stalled cycles.

## Operation
- States: IDLE, WORD, FETCH, DONE.
- Issue:
  - Requests are sampled only in IDLE, at a rising edge.
  - A word op latches `{we, MAR<<2, MDR_q}`. A fetch latches `PC`.
  - `rd` & `wr` together: the write wins, the read is dropped, and `err` pulses.
- Ordering:
  - If a word op and a fetch are issued together, the word op runs first and the fetch is held pending.
  - IDLE→WORD if a word op is issued; IDLE→FETCH if only a fetch is issued.
- WORD:
  - Drive `mem_req`=1, `mem_we`=op, `mem_addr`=MAR<<2, `mem_wdata`=latched MDR.
  - On `mem_ack`: capture read data; go to FETCH if a fetch is pending, else DONE.
- FETCH:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`={PC[ADDR_W-1:2],2'b00}.
  - On `mem_ack`: capture the byte selected by PC[1:0], big-endian (00→[31:24] … 11→[7:0]); go to DONE.
- DONE (one cycle):
  - `mdr_load`=1 if a read completed; `mbr_load`=1 if a fetch completed.
  - `mdr_d`/`mbr_d` hold the captured values.
  - A write produces no load.
  - Next state is IDLE.
- `stall` = (state ≠ IDLE), combinational from state.
- `stall_cnt` increments each cycle `stall`=1 and saturates at all-ones.
- Reset:
  - Any state → IDLE immediately.
  - All outputs 0, including `mem_req`, strobes, `err` and `stall_cnt`.
  - Pending flags and latched address/data are cleared.
  - Reset mid-access abandons the access; no strobe is generated.

## Timing
- Request bits are sampled at edge E0, so the access is visible from E0 onward.
- Zero-wait memory (`mem_ack` in the first request cycle):
  - Read or fetch: `stall` high for 2 cycles (WORD/FETCH, DONE); the load lands at the edge ending DONE.
  - The microinstruction after the stall sees the new MDR/MBR.
- Each wait cycle (`mem_ack`=0) adds one stall cycle.
- `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1.
- Word op plus fetch, both zero-wait: 3 stall cycles, with `mdr_load` and `mbr_load` in the same DONE cycle.
- `mem_ack` is ignored outside WORD/FETCH.
- `mdr_load`, `mbr_load` and `err` are never high for more than one cycle.

## Structure
- Package `mic1_mem_pkg`:
  - State enum.
  - Op encoding (NONE/READ/WRITE).
  - `MIC1_WORD_W`=32.
  - Byte-lane constants.
- Sub-module `mic1_byte_sel`: combinational 32→8 big-endian lane select by PC[1:0], reusable by the datapath.
- The FSM, pending latches and counter live in the top module.

## Test plan
- Read: MAR=0x10, `rd`=1, memory returns 0xDEADBEEF with zero wait → `mem_addr`=0x40, `mem_we`=0, `stall` high 2 cycles, `mdr_d`=0xDEADBEEF with `mdr_load` for one cycle.
- Fetch: PC=0x0000_0006, word 0x11223344 → `mem_addr`=0x4, `mbr_d`=0x33, `mbr_load` for one cycle, `mdr_load`=0.
- Combined: `rd`+`fetch`, MAR=1, PC=3 → WORD then FETCH, addresses 0x4 then 0x0, both strobes in one DONE cycle, `stall_cnt`=3.
- Conflict and waits: `rd`+`wr`, MDR_q=0xA5A5A5A5, `mem_ack` delayed 3 cycles → `err` pulses once, `mem_we`=1 with data held stable, no `mdr_load`, `stall` high 5 cycles.
- Reset mid-access: `rst` asserted in the FETCH state with `mem_ack`=0 → `mem_req`, `stall` and `stall_cnt` are 0 immediately; no strobe after release; next request works normally.
- Counter: 70000 zero-wait reads with CNT_W=16 → `stall_cnt` saturates at 0xFFFF.

Source files
------------

// File: rtl/mic1_mem_pkg.sv
// rtl/mic1_mem_pkg.sv - shared types and constants for the MIC-1 memory arbiter
//
// Purpose:
//   Arbiter FSM state encoding, word-op encoding, the MIC-1 word width and
//   the big-endian byte-lane positions used by the byte selector and by the
//   datapath.
//
// Contents:
//   MIC1_WORD_W  - memory word width (32)
//   LANE_B*_LSB  - bit position of each byte lane inside a word
//   LANE_B*      - PC[1:0] value that selects each lane
//   arb_state_e  - IDLE / WORD / FETCH / DONE
//   mem_op_e     - NONE / READ / WRITE
package mic1_mem_pkg;

  localparam int MIC1_WORD_W = 32;

  // Big-endian: byte address offset 0 is the most significant byte.
  localparam int LANE_B0_LSB = 24;
  localparam int LANE_B1_LSB = 16;
  localparam int LANE_B2_LSB = 8;
  localparam int LANE_B3_LSB = 0;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WORD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } mem_op_e;

endpackage

// File: rtl/mic1_byte_sel.sv
// rtl/mic1_byte_sel.sv - big-endian byte lane select for 32-bit MIC-1 words
//
// Purpose:
//   Picks one byte out of a 32-bit memory word using the low two bits of a
//   byte address. Offset 0 selects bits [31:24], offset 3 selects [7:0].
//   Purely combinational so the datapath can reuse it.
//
// Ports:
//   word_i  in  32 : memory word
//   sel_i   in  2  : byte offset within the word (PC[1:0])
//   byte_o  out 8  : selected byte
module mic1_byte_sel
  import mic1_mem_pkg::*;
(
  input  logic [MIC1_WORD_W-1:0] word_i,
  input  logic [1:0]             sel_i,
  output logic [7:0]             byte_o
);

  always_comb begin
    byte_o = word_i[LANE_B0_LSB +: 8];
    unique case (sel_i)
      LANE_B0: byte_o = word_i[LANE_B0_LSB +: 8];
      LANE_B1: byte_o = word_i[LANE_B1_LSB +: 8];
      LANE_B2: byte_o = word_i[LANE_B2_LSB +: 8];
      LANE_B3: byte_o = word_i[LANE_B3_LSB +: 8];
      default: byte_o = word_i[LANE_B0_LSB +: 8];
    endcase
  end

endmodule

// File: rtl/mic1_mem_arbiter.sv
// rtl/mic1_mem_arbiter.sv - MIC-1 memory port arbiter for word and byte paths
//
// Purpose:
//   Shares the single external memory port between the MAR/MDR word path and
//   the PC/MBR instruction-fetch path. Requests from the current
//   microinstruction are sampled only while idle; a word op always runs
//   before a simultaneous fetch. The control path is frozen through `stall`
//   until the access sequence finishes, and MDR/MBR load strobes fire in the
//   single DONE cycle that ends the sequence.
//
// Parameters:
//   ADDR_W : byte-address width
//   DATA_W : memory word width (MIC-1 uses 32)
//   CNT_W  : width of the saturating stall-cycle counter
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   rd, wr, fetch   : microinstruction memory control bits
//   MAR, MDR_q, PC  : word address, write data, fetch byte address
//   mem_req/we/addr/wdata, mem_ack/rdata : req/ack memory handshake
//   mdr_d, mdr_load : value and one-cycle load strobe for MDR
//   mbr_d, mbr_load : byte and one-cycle load strobe for MBR
//   stall           : high whenever an access sequence is in progress
//   err             : one-cycle pulse when rd and wr were issued together
//   stall_cnt       : saturating count of stalled cycles
module mic1_mem_arbiter
  import mic1_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] MAR,
  input  logic [DATA_W-1:0] MDR_q,
  input  logic [ADDR_W-1:0] PC,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mdr_d,
  output logic              mdr_load,
  output logic [7:0]        mbr_d,
  output logic              mbr_load,
  output logic              stall,
  output logic              err,
  output logic [CNT_W-1:0]  stall_cnt
);

  arb_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic              fetch_q, fetch_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] rdata_cap_q, rdata_cap_d;
  logic [7:0]        mbyte_q, mbyte_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        lane_byte;

  // Byte lane comes from the latched PC, not the live one: the datapath may
  // change PC while the fetch is outstanding.
  mic1_byte_sel u_byte_sel (
    .word_i (mem_rdata),
    .sel_i  (pc_q[1:0]),
    .byte_o (lane_byte)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    fetch_d     = fetch_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    pc_d        = pc_q;
    rdata_cap_d = rdata_cap_q;
    mbyte_d     = mbyte_q;
    err_d       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mdr_load    = 1'b0;
    mbr_load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Write wins a rd/wr conflict; the read is silently dropped.
        if (wr) begin
          op_d = OP_WRITE;
        end else if (rd) begin
          op_d = OP_READ;
        end else begin
          op_d = OP_NONE;
        end
        fetch_d = fetch;
        err_d   = rd & wr;
        if (rd || wr) begin
          waddr_d = MAR << 2;
          wdata_d = MDR_q;
        end
        if (fetch) begin
          pc_d = PC;
        end
        if (rd || wr) begin
          state_d = ST_WORD;
        end else if (fetch) begin
          state_d = ST_FETCH;
        end
      end

      ST_WORD: begin
        mem_req   = 1'b1;
        mem_we    = (op_q == OP_WRITE);
        mem_addr  = waddr_q;
        mem_wdata = wdata_q;
        if (mem_ack) begin
          if (op_q == OP_READ) begin
            rdata_cap_d = mem_rdata;
          end
          state_d = fetch_q ? ST_FETCH : ST_DONE;
        end
      end

      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = {pc_q[ADDR_W-1:2], 2'b00};
        if (mem_ack) begin
          mbyte_d = lane_byte;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // op_q and fetch_q still describe the sequence that just finished,
        // so they directly select which registers get loaded.
        mdr_load = (op_q == OP_READ);
        mbr_load = fetch_q;
        op_d     = OP_NONE;
        fetch_d  = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign stall = (state_q != ST_IDLE);

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NONE;
      fetch_q     <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      rdata_cap_q <= '0;
      mbyte_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      fetch_q     <= fetch_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      pc_q        <= pc_d;
      rdata_cap_q <= rdata_cap_d;
      mbyte_q     <= mbyte_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mdr_d     = rdata_cap_q;
  assign mbr_d     = mbyte_q;
  assign err       = err_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// tb/tb_mic1_mem_arbiter.sv - self-checking bench for mic1_mem_arbiter
module tb_mic1_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0, fetch = 1'b0;
  logic [31:0] MAR = '0, MDR_q = '0, PC = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mdr_d;
  logic        mdr_load;
  logic [7:0]  mbr_d;
  logic        mbr_load;
  logic        stall, err;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  mic1_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .fetch(fetch),
    .MAR(MAR), .MDR_q(MDR_q), .PC(PC),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mdr_d(mdr_d), .mdr_load(mdr_load), .mbr_d(mbr_d), .mbr_load(mbr_load),
    .stall(stall), .err(err), .stall_cnt(stall_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queue of outstanding accesses ----------------
  typedef struct {
    bit          is_fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lane;
  } acc_t;

  acc_t        mq[$];
  acc_t        m_acc;
  bit          m_done = 0, m_got_rd = 0, m_got_fe = 0, m_err = 0;
  logic [31:0] m_mdr = '0;
  logic [7:0]  m_mbr = '0;
  int          m_cnt = 0;

  task automatic model_step();
    if (rst) begin
      mq.delete();
      m_done = 0; m_got_rd = 0; m_got_fe = 0; m_err = 0;
      m_mdr = '0; m_mbr = '0; m_cnt = 0;
    end else begin
      if ((mq.size() != 0 || m_done) && m_cnt < 65535) m_cnt++;
      m_err = 0;
      if (mq.size() != 0) begin
        if (mem_ack) begin
          if (mq[0].is_fetch) m_mbr = 8'((mem_rdata >> (8 * (3 - mq[0].lane))) & 32'hFF);
          else if (!mq[0].we) m_mdr = mem_rdata;
          void'(mq.pop_front());
          if (mq.size() == 0) m_done = 1;
        end
      end else if (m_done) begin
        m_done = 0; m_got_rd = 0; m_got_fe = 0;
      end else begin
        m_got_rd = rd & ~wr;
        m_got_fe = fetch;
        m_err    = rd & wr;
        if (rd || wr) begin
          m_acc.is_fetch = 0; m_acc.we = wr; m_acc.addr = MAR << 2;
          m_acc.wdata = MDR_q; m_acc.lane = 0;
          mq.push_back(m_acc);
        end
        if (fetch) begin
          m_acc.is_fetch = 1; m_acc.we = 0; m_acc.addr = PC & 32'hFFFF_FFFC;
          m_acc.wdata = '0; m_acc.lane = int'(PC % 4);
          mq.push_back(m_acc);
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  // ---------------- compare process ----------------
  bit chk_on = 0;
  bit e_req, e_mdr_ld, e_mbr_ld;

  always @(negedge clk) begin
    if (chk_on) begin
      e_req    = (mq.size() != 0);
      e_mdr_ld = m_done && m_got_rd;
      e_mbr_ld = m_done && m_got_fe;
      chk("stall", stall, e_req || m_done);
      chk("mem_req", mem_req, e_req);
      if (e_req) begin
        chk("mem_addr", mem_addr, mq[0].addr);
        chk("mem_we", mem_we, mq[0].we);
        if (!mq[0].is_fetch) chk("mem_wdata", mem_wdata, mq[0].wdata);
      end
      chk("mdr_load", mdr_load, e_mdr_ld);
      chk("mbr_load", mbr_load, e_mbr_ld);
      if (e_mdr_ld) chk("mdr_d", mdr_d, m_mdr);
      if (e_mbr_ld) chk("mbr_d", mbr_d, m_mbr);
      chk("err", err, m_err);
      chk("stall_cnt", stall_cnt, m_cnt);
    end
  end

  // ---------------- memory responder ----------------
  bit          rand_mode = 0;
  int          wait_cfg = 0, wait_left = 0;
  logic [31:0] rdata_cfg = '0;

  always @(negedge clk) begin
    #1;
    if (rand_mode) begin
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
    end else begin
      mem_rdata = rdata_cfg;
      if (mem_req) begin
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          wait_left = wait_cfg;
        end else begin
          mem_ack = 1'b0;
          wait_left--;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  // ---------------- directed operation with observation ----------------
  int          o_stall, o_mdr, o_mbr, o_both, o_err, o_we, o_nacc;
  logic [31:0] o_addr0, o_addr1, o_mdr_v, o_wd;
  logic [7:0]  o_mbr_v;
  bit          o_wstable;

  task automatic do_op(input bit r, input bit w, input bit f, input logic [31:0] mar,
                       input logic [31:0] mdr, input logic [31:0] pc, input int waits,
                       input logic [31:0] rdv, input int cycles);
    bit          in_req;
    logic [31:0] last_addr, last_wd;
    wait_cfg = waits; wait_left = waits; rdata_cfg = rdv;
    o_stall = 0; o_mdr = 0; o_mbr = 0; o_both = 0; o_err = 0; o_we = 0; o_nacc = 0;
    o_addr0 = 32'hFFFF_FFFF; o_addr1 = 32'hFFFF_FFFF; o_mdr_v = '0; o_mbr_v = '0;
    o_wd = '0; o_wstable = 1; in_req = 0; last_addr = '0; last_wd = '0;
    @(negedge clk); #1;
    rd = r; wr = w; fetch = f; MAR = mar; MDR_q = mdr; PC = pc;
    repeat (cycles) begin
      @(negedge clk);
      if (stall) o_stall++;
      if (mdr_load) begin o_mdr++; o_mdr_v = mdr_d; end
      if (mbr_load) begin o_mbr++; o_mbr_v = mbr_d; end
      if (mdr_load && mbr_load) o_both++;
      if (err) o_err++;
      if (mem_req) begin
        if (mem_we) o_we++;
        o_wd = mem_wdata;
        if (!in_req || mem_addr != last_addr) begin
          if (o_nacc == 0) o_addr0 = mem_addr;
          else if (o_nacc == 1) o_addr1 = mem_addr;
          o_nacc++;
        end else if (mem_wdata != last_wd) begin
          o_wstable = 0;
        end
        last_addr = mem_addr;
        last_wd   = mem_wdata;
      end
      in_req = mem_req;
      #1; rd = 0; wr = 0; fetch = 0;
    end
  endtask

  initial begin
    #1000000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1;
    @(negedge clk);
    chk("reset mem_req", mem_req, 0);
    chk("reset stall", stall, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset err", err, 0);
    #1 rst = 0;

    // Combined rd + fetch, zero wait: word then fetch, 3 stall cycles.
    do_op(1, 0, 1, 32'h1, 32'h0, 32'h3, 0, 32'h1122_3344, 8);
    chk("comb stall cycles", o_stall, 3);
    chk("comb addr0", o_addr0, 32'h4);
    chk("comb addr1", o_addr1, 32'h0);
    chk("comb both loads", o_both, 1);
    chk("comb mdr val", o_mdr_v, 32'h1122_3344);
    chk("comb mbr val", o_mbr_v, 8'h44);
    chk("comb stall_cnt", stall_cnt, 3);

    // Zero-wait read.
    do_op(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 32'hDEAD_BEEF, 6);
    chk("read addr", o_addr0, 32'h40);
    chk("read we cycles", o_we, 0);
    chk("read stall cycles", o_stall, 2);
    chk("read mdr_load count", o_mdr, 1);
    chk("read mdr val", o_mdr_v, 32'hDEAD_BEEF);
    chk("read mbr_load count", o_mbr, 0);

    // Zero-wait fetch.
    do_op(0, 0, 1, 32'h0, 32'h0, 32'h6, 0, 32'h1122_3344, 6);
    chk("fetch addr", o_addr0, 32'h4);
    chk("fetch mbr val", o_mbr_v, 8'h33);
    chk("fetch mbr_load count", o_mbr, 1);
    chk("fetch mdr_load count", o_mdr, 0);
    chk("fetch stall cycles", o_stall, 2);

    // rd + wr conflict with 3 wait cycles.
    do_op(1, 1, 0, 32'h20, 32'hA5A5_A5A5, 32'h0, 3, 32'h0BAD_F00D, 10);
    chk("conflict err count", o_err, 1);
    chk("conflict we cycles", o_we, 4);
    chk("conflict wdata", o_wd, 32'hA5A5_A5A5);
    chk("conflict wdata stable", o_wstable, 1);
    chk("conflict mdr_load count", o_mdr, 0);
    chk("conflict stall cycles", o_stall, 5);

    // Reset in the middle of a fetch that is never acknowledged.
    do_op(0, 0, 1, 32'h0, 32'h0, 32'h100, 1000, 32'h0, 3);
    chk("pre-reset in fetch", mem_req, 1);
    rst = 1;
    #1;
    chk("midrst mem_req", mem_req, 0);
    chk("midrst stall", stall, 0);
    chk("midrst stall_cnt", stall_cnt, 0);
    @(negedge clk); #1 rst = 0;
    do_op(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 5);
    chk("post-reset strobes", o_mdr + o_mbr, 0);
    chk("post-reset stall", o_stall, 0);
    do_op(1, 0, 0, 32'h7, 32'h0, 32'h0, 1, 32'hCAFE_0001, 8);
    chk("post-reset read addr", o_addr0, 32'h1C);
    chk("post-reset read val", o_mdr_v, 32'hCAFE_0001);
    chk("post-reset read stall", o_stall, 3);

    // Randomised traffic with random acks and occasional resets.
    rand_mode = 1;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk); #1;
      rst   = ($urandom_range(0, 299) == 0);
      rd    = ($urandom_range(0, 3) == 0);
      wr    = ($urandom_range(0, 3) == 0);
      fetch = ($urandom_range(0, 2) == 0);
      MAR   = $urandom; MDR_q = $urandom; PC = $urandom;
    end
    @(negedge clk); #1;
    rst = 0; rd = 0; wr = 0; fetch = 0;
    rand_mode = 0;
    repeat (8) @(negedge clk);

    // One very long read drives the counter into saturation.
    do_op(1, 0, 0, 32'h3, 32'h0, 32'h0, 66000, 32'h5A5A_0FF0, 66010);
    chk("sat stall_cnt", stall_cnt, 16'hFFFF);
    chk("sat read completes", o_mdr, 1);
    chk("sat read val", o_mdr_v, 32'h5A5A_0FF0);
    repeat (4) @(negedge clk);
    chk("sat stall_cnt held", stall_cnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
